seg7_scan: RTL

Four-digit multiplexed seven-segment display driver that sits directly downstream of the 16-bit event counter and renders its count as four hexadecimal digits. It snapshots the 16-bit value once per display frame so a digit never tears mid-frame. It scans the digits at a rate set by an internal prescaler and drives active-low anode and segment lines straight to the board pins.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_hex.sv | 20 ++
 rtl/seg7_scan.sv | 98 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seg7_scan display driver.
// Revision: 1.0
`default_nettype none

package seg7_pkg;

  typedef logic [7:0] seg7_t;

  localparam seg7_t SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is off (1) in every entry.
  localparam seg7_t HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = AN_DIG0;
      2'd1:    pat = AN_DIG1;
      2'd2:    pat = AN_DIG2;
      default: pat = AN_DIG3;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_hex.sv
// hex_to_seg7: combinational nibble to active-low gfedcba decoder with blanking.
// Revision: 1.0
`default_nettype none

module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  seg7_t w_code;

  assign w_code = HEX_SEG[i_nibble];
  assign o_seg  = i_blank ? SEG_BLANK[6:0] : w_code[6:0];

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed hex display driver with per-frame snapshot.
// Optional macro SEG7_LEAD_ZERO_BLANK_EN blanks leading zero digits. Revision: 1.0
`default_nettype none

module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:15] din,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int              PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   c_PMAX = PW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || SCAN_DIV > 65536) begin : g_bad_div
    $error("seg7_scan: SCAN_DIV out of range 2..65536");
  end

  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [3:0]    r_dp_snap;
  logic          r_upd;
  logic          r_frame;
  logic [3:0]    r_an;
  seg7_t         r_seg;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_gfedcba;

  assign w_tick   = (r_pcnt == c_PMAX);
  assign w_wrap   = w_tick && (r_idx == 2'd3);
  assign w_nibble = r_snap[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // A digit is a leading zero when it and every nibble above it are zero.
  assign w_blank = (r_idx != 2'd0) && ((r_snap >> {r_idx, 2'b00}) == 16'h0000);
`else
  assign w_blank = 1'b0;
`endif

  hex_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_gfedcba)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt    <= '0;
      r_idx     <= 2'd3;
      r_snap    <= '0;
      r_dp_snap <= '0;
      r_upd     <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_pcnt  <= w_tick ? '0 : r_pcnt + PW'(1);
      r_upd   <= w_tick;
      r_frame <= w_wrap;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      // Inputs are only sampled at the frame boundary so a frame never tears.
      if (w_wrap) begin
        r_snap    <= din;
        r_dp_snap <= dp_in;
      end
    end
  end

  // Display registers follow idx one cycle after each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else if (r_upd) begin
      r_an  <= an_for_idx(r_idx);
      r_seg <= {~r_dp_snap[r_idx], w_gfedcba};
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = r_frame;

endmodule

`default_nettype wire
